key_event_sched: RTL and testbench



---
 rtl/key_event_sched.sv | 201 ++++++++++++++++++++
 tb/tb_key_event_sched.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_sched.sv
// key_event_sched: round-robin merge of per-key press/release pulses into a FWFT event FIFO.
// Define KEY_REPEAT_EN to add per-key hold-to-repeat timers that emit type 2'b10 events.
module key_event_sched #(
    parameter int N_KEYS     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int T_HOLD     = 25_000_000,
    parameter int T_REPEAT   = 5_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_KEYS-1:0]         press_flag,
    input  logic [N_KEYS-1:0]         release_flag,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(N_KEYS)-1:0] evt_key,
    output logic [1:0]                evt_type,
    output logic                      ovf,
    input  logic                      ovf_clr
);
    localparam int KW = $clog2(N_KEYS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = KW + 2;

    localparam logic [1:0] TYPE_PRESS   = 2'b00;
    localparam logic [1:0] TYPE_RELEASE = 2'b01;
    localparam logic [1:0] TYPE_REPEAT  = 2'b10;

    if (N_KEYS < 2 || N_KEYS > 8 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        T_HOLD < 1 || T_REPEAT < 1) begin : g_cfg_check
        $error("key_event_sched: unsupported parameter set");
    end

    logic [N_KEYS-1:0] r_p;
    logic [N_KEYS-1:0] r_r;
    logic [N_KEYS-1:0] r_t;
    logic [N_KEYS-1:0] w_req;
    logic [N_KEYS-1:0] w_fire;
    logic [N_KEYS-1:0] w_gnt_p;
    logic [N_KEYS-1:0] w_gnt_r;
    logic [N_KEYS-1:0] w_gnt_t;
    logic [KW-1:0]     r_rr;
    logic [KW-1:0]     w_gnt_idx;
    logic [KW-1:0]     w_k;
    logic [KW:0]       w_sum;
    logic              w_gnt_any;
    logic              w_gnt;
    logic [1:0]        w_gnt_type;
    logic [AW:0]       r_wr;
    logic [AW:0]       r_rd;
    logic [EW-1:0]     r_mem [FIFO_DEPTH];
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              r_ovf;
    logic              w_ovf_set;

    assign w_req = r_p | r_r | r_t;

    // Scan keys starting at the round-robin pointer, wrapping modulo N_KEYS.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_k       = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            w_sum = {1'b0, r_rr} + (KW+1)'(i);
            if (w_sum >= (KW+1)'(N_KEYS)) begin
                w_sum = w_sum - (KW+1)'(N_KEYS);
            end
            w_k = w_sum[KW-1:0];
            if (!w_gnt_any && w_req[w_k]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_k;
            end
        end
    end

    assign w_gnt = w_gnt_any && !w_full;

    always_comb begin
        w_gnt_p    = '0;
        w_gnt_r    = '0;
        w_gnt_t    = '0;
        w_gnt_type = TYPE_PRESS;
        if (w_gnt) begin
            if (r_p[w_gnt_idx]) begin
                w_gnt_p[w_gnt_idx] = 1'b1;
                w_gnt_type         = TYPE_PRESS;
            end else if (r_r[w_gnt_idx]) begin
                w_gnt_r[w_gnt_idx] = 1'b1;
                w_gnt_type         = TYPE_RELEASE;
            end else begin
                w_gnt_t[w_gnt_idx] = 1'b1;
                w_gnt_type         = TYPE_REPEAT;
            end
        end
    end

    // A pulse landing on a bit being granted this cycle reloads it without overflow.
    assign w_ovf_set = |((r_p & ~w_gnt_p & press_flag) | (r_r & ~w_gnt_r & release_flag));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p  <= '0;
            r_r  <= '0;
            r_t  <= '0;
            r_rr <= '0;
        end else begin
            r_p <= (r_p & ~w_gnt_p) | press_flag;
            r_r <= (r_r & ~w_gnt_r) | release_flag;
            r_t <= ((r_t & ~w_gnt_t) | w_fire) & ~release_flag;
            if (w_gnt) begin
                r_rr <= (w_gnt_idx == KW'(N_KEYS - 1)) ? '0 : w_gnt_idx + KW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = !w_empty && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_gnt) begin
                r_mem[r_wr[AW-1:0]] <= {w_gnt_idx, w_gnt_type};
                r_wr                <= r_wr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + (AW+1)'(1);
            end
        end
    end

    assign evt_valid           = !w_empty;
    assign {evt_key, evt_type} = r_mem[r_rd[AW-1:0]];

`ifdef KEY_REPEAT_EN
    localparam logic [31:0] HOLD_LIM = 32'(T_HOLD - 1);
    localparam logic [31:0] REP_LIM  = 32'(T_REPEAT - 1);

    logic [N_KEYS-1:0] r_held;
    logic [N_KEYS-1:0] r_first;
    logic [31:0]       r_timer [N_KEYS];

    always_comb begin
        w_fire = '0;
        for (int unsigned k = 0; k < N_KEYS; k++) begin
            w_fire[k] = r_held[k] && (r_timer[k] == (r_first[k] ? HOLD_LIM : REP_LIM));
        end
    end

    // A release both ends the hold and restarts the timer toward the long first delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held  <= '0;
            r_first <= '1;
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                r_timer[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_KEYS; k++) begin
                if (release_flag[k]) begin
                    r_held[k] <= 1'b0;
                end else if (w_gnt_p[k]) begin
                    r_held[k] <= 1'b1;
                end
                if (!r_held[k] || release_flag[k]) begin
                    r_timer[k] <= '0;
                    r_first[k] <= 1'b1;
                end else if (w_fire[k]) begin
                    r_timer[k] <= '0;
                    r_first[k] <= 1'b0;
                end else begin
                    r_timer[k] <= r_timer[k] + 32'd1;
                end
            end
        end
    end
`else
    assign w_fire = '0;
`endif

endmodule

// File: tb/tb_key_event_sched.sv
// Scoreboard bench for key_event_sched; the repeat scenario runs only when KEY_REPEAT_EN is defined.
module tb_key_event_sched;
    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] press_flag;
    logic [NK-1:0] release_flag;
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_key;
    logic [1:0]    evt_type;
    logic          ovf;
    logic          ovf_clr;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_e;

    key_event_sched #(
        .N_KEYS    (NK),
        .FIFO_DEPTH(4),
        .T_HOLD    (20),
        .T_REPEAT  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .press_flag  (press_flag),
        .release_flag(release_flag),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_key     (evt_key),
        .evt_type    (evt_type),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic reset_dut();
        rst_n        = 1'b0;
        press_flag   = '0;
        release_flag = '0;
        evt_ready    = 1'b0;
        ovf_clr      = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        press_flag   = '0;
        release_flag = '0;
        evt_ready    = 1'b0;
        ovf_clr      = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", evt_valid); end
        n_checks++;
        if (evt_key !== 2'd0) begin n_errors++; $display("FAIL reset_key: got %0d expected 0", evt_key); end
        n_checks++;
        if (evt_type !== 2'b00) begin n_errors++; $display("FAIL reset_type: got %b expected 00", evt_type); end
        n_checks++;
        if (ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        evt_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 0) press_flag = 4'b0100;
            else        release_flag = 4'b0100;
            exp_q.push_back({2'd2, (k == 0) ? 2'b00 : 2'b01});
            @(negedge clk);
            press_flag   = '0;
            release_flag = '0;
            n_checks++;
            if (evt_valid !== 1'b0) begin
                n_errors++; $display("FAIL single_early k=%0d: evt_valid=%b expected 0", k, evt_valid);
            end
            @(negedge clk);
            exp_e = exp_q.pop_front();
            n_checks++;
            if (evt_valid !== 1'b1 || {evt_key, evt_type} !== exp_e) begin
                n_errors++;
                $display("FAIL single_event k=%0d: valid=%b entry=%h expected valid=1 entry=%h",
                         k, evt_valid, {evt_key, evt_type}, exp_e);
            end
            @(negedge clk);
            n_checks++;
            if (evt_valid !== 1'b0) begin
                n_errors++; $display("FAIL single_one_cycle k=%0d: evt_valid=%b expected 0", k, evt_valid);
            end
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_all_keys();
        logic [1:0] kk;
        reset_dut();
        press_flag = 4'hF;
        for (int k = 0; k < NK; k++) begin
            kk = 2'(k);
            exp_q.push_back({kk, 2'b00});
        end
        @(negedge clk);
        press_flag = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (evt_valid !== 1'b1 || evt_key !== 2'd0) begin
                n_errors++; $display("FAIL all_head_hold i=%0d: valid=%b key=%0d expected valid=1 key=0", i, evt_valid, evt_key);
            end
        end
        press_flag = 4'b0010;
        exp_q.push_back({2'd1, 2'b00});
        @(negedge clk);
        press_flag = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (evt_valid !== 1'b1 || evt_key !== 2'd0 || ovf !== 1'b0) begin
                n_errors++;
                $display("FAIL full_wait i=%0d: valid=%b key=%0d ovf=%b expected valid=1 key=0 ovf=0", i, evt_valid, evt_key, ovf);
            end
        end
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid === 1'b1) begin
                exp_e = exp_q.pop_front();
                n_checks++;
                if ({evt_key, evt_type} !== exp_e) begin
                    n_errors++; $display("FAIL all_drain: entry=%h expected %h", {evt_key, evt_type}, exp_e);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_errors++; $display("FAIL all_drain_timeout: %0d events missing, expected 0", exp_q.size()); end
        n_checks++;
        if (evt_valid !== 1'b0 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL all_after: valid=%b ovf=%b expected 0 0", evt_valid, ovf);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_ovf();
        reset_dut();
        evt_ready  = 1'b1;
        press_flag = 4'b0001;
        exp_q.push_back({2'd0, 2'b00});
        @(negedge clk);
        press_flag = 4'b0001;
        exp_q.push_back({2'd0, 2'b00});
        @(negedge clk);
        press_flag = '0;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (evt_valid === 1'b1) begin
                exp_e = exp_q.pop_front();
                n_checks++;
                if ({evt_key, evt_type} !== exp_e) begin
                    n_errors++; $display("FAIL reload_drain: entry=%h expected %h", {evt_key, evt_type}, exp_e);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL reload_ovf: missing=%0d ovf=%b expected 0 0", exp_q.size(), ovf);
        end

        evt_ready  = 1'b0;
        press_flag = 4'hF;
        exp_q.push_back({2'd1, 2'b00});
        exp_q.push_back({2'd2, 2'b00});
        exp_q.push_back({2'd3, 2'b00});
        exp_q.push_back({2'd0, 2'b00});
        @(negedge clk);
        press_flag = '0;
        repeat (5) @(negedge clk);
        press_flag = 4'b0001;
        exp_q.push_back({2'd0, 2'b00});
        @(negedge clk);
        press_flag = '0;
        n_checks++;
        if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_first_pending: got %b expected 0", ovf); end
        press_flag = 4'b0001;
        @(negedge clk);
        press_flag = '0;
        n_checks++;
        if (ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
        evt_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (evt_valid === 1'b1) begin
                exp_e = exp_q.pop_front();
                n_checks++;
                if ({evt_key, evt_type} !== exp_e) begin
                    n_errors++; $display("FAIL ovf_drain: entry=%h expected %h", {evt_key, evt_type}, exp_e);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0 || evt_valid !== 1'b0) begin
            n_errors++; $display("FAIL ovf_drain_end: missing=%0d valid=%b expected 0 0", exp_q.size(), evt_valid);
        end
        evt_ready = 1'b0;
    endtask

`ifdef KEY_REPEAT_EN
    task automatic test_repeat();
        int t_press;
        int t_rep1;
        int t_rep2;
        int n_rep;
        t_press = -1;
        t_rep1  = -1;
        t_rep2  = -1;
        n_rep   = 0;
        reset_dut();
        evt_ready = 1'b1;
        exp_q.push_back({2'd3, 2'b00});
        exp_q.push_back({2'd3, 2'b10});
        exp_q.push_back({2'd3, 2'b10});
        exp_q.push_back({2'd3, 2'b01});
        for (int c = 0; c < 80; c++) begin
            if (evt_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL rep_extra c=%0d: entry=%h expected none", c, {evt_key, evt_type});
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({evt_key, evt_type} !== exp_e) begin
                        n_errors++; $display("FAIL rep_seq c=%0d: entry=%h expected %h", c, {evt_key, evt_type}, exp_e);
                    end
                end
                if (evt_type == 2'b00) t_press = c;
                else if (evt_type == 2'b10) begin
                    n_rep++;
                    if (n_rep == 1) t_rep1 = c;
                    else t_rep2 = c;
                end
            end
            press_flag   = (c == 0)  ? 4'b1000 : 4'b0000;
            release_flag = (c == 34) ? 4'b1000 : 4'b0000;
            @(negedge clk);
        end
        n_checks++;
        if (n_rep != 2 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL rep_count: repeats=%0d missing=%0d expected 2 0", n_rep, exp_q.size());
        end
        n_checks++;
        if (t_rep1 - t_press < 19 || t_rep1 - t_press > 22) begin
            n_errors++; $display("FAIL rep_first_gap: got %0d expected 19..22", t_rep1 - t_press);
        end
        n_checks++;
        if (t_rep2 - t_rep1 < 7 || t_rep2 - t_rep1 > 9) begin
            n_errors++; $display("FAIL rep_next_gap: got %0d expected 7..9", t_rep2 - t_rep1);
        end
        evt_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        reset_dut();
        press_flag = 4'b0111;
        @(negedge clk);
        press_flag = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (evt_valid !== 1'b1) begin n_errors++; $display("FAIL mid_queued: valid=%b expected 1", evt_valid); end
        press_flag = 4'b1000;
        @(negedge clk);
        press_flag = 4'b0001;
        @(negedge clk);
        press_flag = 4'b0001;
        @(negedge clk);
        press_flag = '0;
        n_checks++;
        if (ovf !== 1'b1) begin n_errors++; $display("FAIL mid_ovf_pre: got %b expected 1", ovf); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (evt_valid !== 1'b0 || ovf !== 1'b0) begin
            n_errors++; $display("FAIL mid_async: valid=%b ovf=%b expected 0 0", evt_valid, ovf);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (evt_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_errors++; $display("FAIL mid_after: valid cycles=%0d expected 0", seen); end
        evt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_keys();
        test_ovf();
`ifdef KEY_REPEAT_EN
        test_repeat();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
